// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with HI/LO registers: 32-cycle shift-add multiply,
// 32-cycle restoring divide on operand magnitudes, and a final sign-fix cycle.
// IDLE: waiting, mthi/mtlo | CALC: one iteration per cycle | FIX: sign fix, HI/LO write
module mdu_iterative (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MDCode,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dvz_q, dvz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum;
  logic [63:0] mult_next;
  logic [32:0] dshift;
  logic        dge;
  logic [31:0] dsub;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign a_neg = ~MDCode[0] & A[31];
  assign b_neg = ~MDCode[0] & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign msum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mult_next = {msum, acc_q[31:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}
  assign dshift   = {acc_q[63:32], acc_q[31]};
  assign dge      = dshift >= {1'b0, opnd_q};
  assign dsub     = dshift[31:0] - opnd_q;
  assign div_next = {(dge ? dsub : dshift[31:0]), acc_q[30:0], dge};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          if (!MDCode[2]) begin
            is_div_d  = MDCode[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dvz_d     = (B == 32'd0);
            acc_d     = MDCode[1] ? {32'd0, a_mag} : {32'd0, b_mag};
            opnd_d    = MDCode[1] ? b_mag : a_mag;
            cnt_d     = 5'd0;
            state_d   = CALC;
          end else if (MDCode == 3'b100) begin
            hi_d = A;
          end else if (MDCode == 3'b101) begin
            lo_d = A;
          end
        end
      end
      CALC: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mult_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!Flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = dvz_q ? 32'hFFFF_FFFF : quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dvz_q     <= dvz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected {HI,LO} queued at issue, popped and
// compared by a monitor whenever Done is seen.
module tb_mdu_iterative;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  MDCode;
  logic        Start;
  logic [31:0] A, B;
  logic        Flush;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_iterative dut (
    .clk(clk), .rst_n(rst_n), .MDCode(MDCode), .Start(Start), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural meaning of each op
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa64, sb64;
    int     sa, sb;
    logic [63:0] r;
    r = 64'd0;
    case (op)
      3'd0: begin
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        r = 64'(sa64 * sb64);
      end
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          sa = a;
          sb = b;
          r = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {HI, LO}, mon_e);
        check("done_not_busy", {63'd0, Busy}, 64'd0);
        hi_m = mon_e[63:32];
        lo_m = mon_e[31:0];
      end
    end
  end

  // Called at a negedge with the DUT idle; returns just after the accept edge
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDCode = op; A = a; B = b; Start = 1'b1;
    exp_q.push_back(ref_model(op, a, b));
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(input int pre, input string name);
    int cnt;
    bit ok;
    cnt = pre;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Busy) cnt++;
      else begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 64'd1, 64'd0);
    else begin
      check({name, "_busy_cycles"}, 64'(cnt), 64'd33);
      check({name, "_done"}, {63'd0, Done}, 64'd1);
    end
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
    MDCode = op; A = a; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    if (op == 3'd4) hi_m = a;
    else lo_m = a;
    check("mt_hilo", {HI, LO}, {hi_m, lo_m});
    check("mt_busy", {63'd0, Busy}, 64'd0);
    @(negedge clk);
    check("mt_no_done", {63'd0, Done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, ra, rb;
    logic [2:0]  rop;
    bit          seen, was_busy;

    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; MDCode = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done(0, "mult");
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("done_one_cycle", {63'd0, Done}, 64'd0);

    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, "multu");
    check("multu_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, "div_neg");
    check("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, "div_ovf");
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

    start_op(3'd3, 32'd100, 32'd0);
    wait_done(0, "divu_zero");
    check("divu_zero_const", {HI, LO}, 64'h0000_0064_FFFF_FFFF);

    start_op(3'd2, 32'hFFFF_FFF0, 32'd0);
    wait_done(0, "div_zero");
    check("div_zero_const", {HI, LO}, 64'hFFFF_FFF0_FFFF_FFFF);

    mt_op(3'd4, 32'h1234_5678);
    check("mthi_const", {32'd0, HI}, 64'h1234_5678);
    mt_op(3'd5, 32'h0BAD_F00D);

    // mtlo issued while busy must be dropped
    start_op(3'd1, 32'h0001_0001, 32'h0003_0003);
    @(negedge clk);
    MDCode = 3'd5; A = 32'hCAFE_BABE; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done(1, "multu_mtlo");
    check("mtlo_ignored", {HI, LO}, 64'h0000_0003_0006_0003);

    // Flush during CALC
    start_op(3'd2, 32'd1000, 32'd7);
    h = hi_m; l = lo_m;
    repeat (10) @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_calc_busy", {63'd0, Busy}, 64'd0);
    check("flush_calc_hilo", {HI, LO}, {h, l});
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (Done) seen = 1'b1; end
    check("flush_calc_no_done", {63'd0, seen}, 64'd0);

    // Flush in the FIX cycle
    start_op(3'd0, 32'h7FFF_0001, 32'h0000_1234);
    repeat (33) @(negedge clk);
    was_busy = Busy;
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_fix_was_busy", {63'd0, was_busy}, 64'd1);
    check("flush_fix_hilo", {HI, LO}, {h, l});
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (Done) seen = 1'b1; end
    check("flush_fix_no_done", {62'd0, seen, Busy}, 64'd0);

    // Start cancelled by Flush in IDLE
    MDCode = 3'd4; A = 32'h5555_AAAA; Start = 1'b1; Flush = 1'b1;
    @(posedge clk);
    #1;
    MDCode = 3'd0;
    @(posedge clk);
    #1 Start = 1'b0; Flush = 1'b0;
    check("flush_start_hilo", {HI, LO}, {h, l});
    check("flush_start_busy", {63'd0, Busy}, 64'd0);
    @(negedge clk);

    // Reset mid-operation, with a Start held during reset
    start_op(3'd2, 32'h1234_5678, 32'd3);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    MDCode = 3'd4; A = 32'hDEAD_BEEF; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    void'(exp_q.pop_back());
    hi_m = 32'd0; lo_m = 32'd0;
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_busy_done", {62'd0, Busy, Done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random back-to-back traffic
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      start_op(rop, ra, rb);
      wait_done(0, "rand");
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
